// File: rtl/nave_controle_if.sv
// Bus between the VGA timing/button side and the ship/shot controller.
// The master drives the counters and buttons; the slave drives ship and shot state.
interface nave_controle_if;
  logic [9:0]  h_counter;
  logic [9:0]  v_counter;
  logic        btn_left;
  logic        btn_right;
  logic        btn_fire;
  logic [10:0] mem_X_barra;
  logic        shot_active;
  logic [10:0] shot_x;
  logic [9:0]  shot_y;
  logic        frame_tick;

  modport master (
    output h_counter, v_counter, btn_left, btn_right, btn_fire,
    input  mem_X_barra, shot_active, shot_x, shot_y, frame_tick
  );

  modport slave (
    input  h_counter, v_counter, btn_left, btn_right, btn_fire,
    output mem_X_barra, shot_active, shot_x, shot_y, frame_tick
  );
endinterface

// File: rtl/nave_controle.sv
// Ship and single-shot controller: everything updates once per frame during
// vertical blanking so the renderers never see a mid-frame change.
module nave_controle #(
  parameter int unsigned SCREEN_W   = 640,
  parameter int unsigned SHIP_W     = 11,
  parameter int unsigned SHIP_Y     = 150,
  parameter int unsigned START_X    = 314,
  parameter int unsigned SPEED      = 2,
  parameter int unsigned SHOT_SPEED = 4,
  parameter int unsigned FRAME_LINE = 480
) (
  input  logic             clk,
  input  logic             reset_n,
  nave_controle_if.slave   bus
);

  localparam logic [10:0] X_MAX     = 11'(SCREEN_W - SHIP_W);
  localparam logic [10:0] X_RESET   = 11'(START_X);
  localparam logic [10:0] STEP      = 11'(SPEED);
  localparam logic [10:0] HALF_W    = 11'(SHIP_W / 2);
  localparam logic [9:0]  Y_LAUNCH  = 10'(SHIP_Y - 1);
  localparam logic [9:0]  SHOT_STEP = 10'(SHOT_SPEED);
  localparam logic [9:0]  LINE      = 10'(FRAME_LINE);

  // Button bit order throughout: {fire, right, left}
  logic [2:0]  btn_s1, btn_s2;
  logic        fire_prev;
  logic        match, match_d;
  logic        frame_tick_q;
  logic        fire_pending, pending_next;

  logic [10:0] x_q, x_next;
  logic        shot_active_q, shot_active_next;
  logic [10:0] shot_x_q, shot_x_next;
  logic [9:0]  shot_y_q, shot_y_next;

  logic        left_s, right_s, fire_rise;

  assign match     = (bus.v_counter == LINE) && (bus.h_counter == 10'd0);
  assign left_s    = btn_s2[0];
  assign right_s   = btn_s2[1];
  assign fire_rise = btn_s2[2] & ~fire_prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_s1        <= '0;
      btn_s2        <= '0;
      fire_prev     <= 1'b0;
      match_d       <= 1'b0;
      frame_tick_q  <= 1'b0;
      fire_pending  <= 1'b0;
      x_q           <= X_RESET;
      shot_active_q <= 1'b0;
      shot_x_q      <= '0;
      shot_y_q      <= '0;
    end else begin
      btn_s1        <= {bus.btn_fire, bus.btn_right, bus.btn_left};
      btn_s2        <= btn_s1;
      fire_prev     <= btn_s2[2];
      match_d       <= match;
      // A counter pair held on the match value for many clocks still yields one pulse
      frame_tick_q  <= match & ~match_d;
      fire_pending  <= pending_next;
      x_q           <= x_next;
      shot_active_q <= shot_active_next;
      shot_x_q      <= shot_x_next;
      shot_y_q      <= shot_y_next;
    end
  end

  always_comb begin
    x_next           = x_q;
    shot_active_next = shot_active_q;
    shot_x_next      = shot_x_q;
    shot_y_next      = shot_y_q;
    pending_next     = fire_pending;

    if (frame_tick_q) begin
      // Compare before stepping so the 11-bit position never underflows or overshoots
      if (left_s && !right_s) begin
        x_next = (x_q >= STEP) ? (x_q - STEP) : 11'd0;
      end else if (right_s && !left_s) begin
        x_next = ((x_q + STEP) <= X_MAX) ? (x_q + STEP) : X_MAX;
      end

      if (shot_active_q) begin
        if (shot_y_q < SHOT_STEP) begin
          shot_active_next = 1'b0;
        end else begin
          shot_y_next = shot_y_q - SHOT_STEP;
        end
      end else if (fire_pending) begin
        shot_active_next = 1'b1;
        shot_x_next      = x_q + HALF_W;
        shot_y_next      = Y_LAUNCH;
        pending_next     = 1'b0;
      end
    end

    // Evaluated after launch so an edge on the tick cycle queues for the next frame
    if (fire_rise && !shot_active_q) begin
      pending_next = 1'b1;
    end
  end

  assign bus.mem_X_barra = x_q;
  assign bus.shot_active = shot_active_q;
  assign bus.shot_x      = shot_x_q;
  assign bus.shot_y      = shot_y_q;
  assign bus.frame_tick  = frame_tick_q;

endmodule
